// File: rtl/jedro_1_mem_arbiter.sv
// rtl/jedro_1_mem_arbiter.sv - single-port memory arbiter between instruction fetch and LSU
// One outstanding transaction; data has priority, a starvation counter guarantees fetch progress.
module jedro_1_mem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            instr_req_i,
   input  logic [AW-1:0]   instr_addr_i,
   output logic            instr_gnt_o,
   output logic            instr_rvalid_o,
   output logic [DW-1:0]   instr_rdata_o,
   input  logic            data_req_i,
   input  logic            data_we_i,
   input  logic [DW/8-1:0] data_be_i,
   input  logic [AW-1:0]   data_addr_i,
   input  logic [DW-1:0]   data_wdata_i,
   output logic            data_gnt_o,
   output logic            data_rvalid_o,
   output logic [DW-1:0]   data_rdata_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [DW/8-1:0] mem_be_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [DW-1:0]   mem_rdata_i
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t          state;
   logic            owner_instr;
   logic [CW-1:0]   starve_cnt;
   logic            fetch_wins;
   logic            in_req;
   logic            in_resp;

   assign fetch_wins = instr_req_i && (!data_req_i || (starve_cnt == CW'(MAX_WAIT)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         owner_instr <= 1'b0;
         starve_cnt  <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_be_o    <= '0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (instr_req_i || data_req_i) begin
                  state       <= REQ;
                  mem_req_o   <= 1'b1;
                  owner_instr <= fetch_wins;
                  if (fetch_wins) begin
                     mem_we_o    <= 1'b0;
                     mem_be_o    <= '1;
                     mem_addr_o  <= instr_addr_i;
                     mem_wdata_o <= '0;
                  end else begin
                     mem_we_o    <= data_we_i;
                     mem_be_o    <= data_be_i;
                     mem_addr_o  <= data_addr_i;
                     mem_wdata_o <= data_wdata_i;
                  end
                  // Only a fetch that actually competed moves the starvation count.
                  if (instr_req_i) begin
                     if (fetch_wins)
                        starve_cnt <= '0;
                     else if (starve_cnt != CW'(MAX_WAIT))
                        starve_cnt <= starve_cnt + CW'(1);
                  end
               end
            end
            REQ: begin
               if (mem_gnt_i) begin
                  state     <= RESP;
                  mem_req_o <= 1'b0;
               end
            end
            RESP: begin
               if (mem_rvalid_i)
                  state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               mem_req_o <= 1'b0;
            end
         endcase
      end
   end

   // Gating with reset keeps a response arriving during reset from being routed.
   assign in_req  = (state == REQ)  && !rst_i;
   assign in_resp = (state == RESP) && !rst_i;

   assign instr_gnt_o    = in_req  &&  owner_instr && mem_gnt_i;
   assign data_gnt_o     = in_req  && !owner_instr && mem_gnt_i;
   assign instr_rvalid_o = in_resp &&  owner_instr && mem_rvalid_i;
   assign data_rvalid_o  = in_resp && !owner_instr && mem_rvalid_i;

   assign instr_rdata_o = mem_rdata_i;
   assign data_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// tb/tb_jedro_1_mem_arbiter.sv - self-checking bench for jedro_1_mem_arbiter
module tb_jedro_1_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   always #5 clk_i = ~clk_i;

   jedro_1_mem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
      .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   typedef struct {
      logic        ireq, dreq, gnt, rv;
      logic        e_req, e_igt, e_dgt, e_irv, e_drv;
      logic        chk_bus;
      logic [31:0] e_addr;
      logic        e_we;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
   } vec_t;

   vec_t vt[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(logic ireq, logic dreq, logic gnt, logic rv,
                               logic e_req, logic e_igt, logic e_dgt, logic e_irv, logic e_drv,
                               logic chk_bus, logic [31:0] e_addr, logic e_we,
                               logic [3:0] e_be, logic [31:0] e_wdata);
      vec_t v;
      v.ireq = ireq; v.dreq = dreq; v.gnt = gnt; v.rv = rv;
      v.e_req = e_req; v.e_igt = e_igt; v.e_dgt = e_dgt; v.e_irv = e_irv; v.e_drv = e_drv;
      v.chk_bus = chk_bus; v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wdata;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic rst, input logic ireq, input logic dreq,
                       input logic gnt, input logic rv);
      @(posedge clk_i);
      #1;
      rst_i = rst; instr_req_i = ireq; data_req_i = dreq; mem_gnt_i = gnt; mem_rvalid_i = rv;
      @(negedge clk_i);
   endtask

   initial begin
      int   grants;
      int   last_cyc;
      logic exp_i;

      rst_i = 1'b1; instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      instr_addr_i = 32'h100;
      data_we_i = 1'b1; data_be_i = 4'b0011; data_addr_i = 32'h204; data_wdata_i = 32'hCAFEBABE;
      mem_rdata_i = 32'h00000013;

      //             ireq dreq gnt rv  req igt dgt irv drv bus addr       we  be    wdata
      vt.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 32'h0,   0, 4'h0, 32'h0));        // reset state
      vt.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 0,  0, 32'h0,   0, 4'h0, 32'h0));        // stray rvalid
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 32'h0,   0, 4'h0, 32'h0));        // fetch arb
      vt.push_back(mk(1, 0, 1, 0,  1, 1, 0, 0, 0,  1, 32'h100, 0, 4'hF, 32'h0));        // fetch gnt
      vt.push_back(mk(0, 0, 0, 1,  0, 0, 0, 1, 0,  0, 32'h0,   0, 4'h0, 32'h0));        // fetch rvalid
      vt.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 0,  0, 32'h0,   0, 4'h0, 32'h0));        // store arb
      vt.push_back(mk(0, 1, 1, 0,  1, 0, 1, 0, 0,  1, 32'h204, 1, 4'h3, 32'hCAFEBABE)); // store gnt
      vt.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0, 1,  0, 32'h0,   0, 4'h0, 32'h0));        // store rvalid
      vt.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0,  0, 32'h0,   0, 4'h0, 32'h0));        // stall arb
      for (int i = 0; i < 5; i++)
         vt.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 0,  1, 32'h100, 0, 4'hF, 32'h0));     // stalled
      vt.push_back(mk(1, 0, 1, 0,  1, 1, 0, 0, 0,  1, 32'h100, 0, 4'hF, 32'h0));        // stall gnt
      vt.push_back(mk(0, 0, 1, 0,  0, 0, 0, 0, 0,  0, 32'h0,   0, 4'h0, 32'h0));        // gnt in RESP
      vt.push_back(mk(0, 0, 0, 1,  0, 0, 0, 1, 0,  0, 32'h0,   0, 4'h0, 32'h0));        // stall rvalid

      repeat (2) @(posedge clk_i);
      foreach (vt[k]) begin
         step(1'b0, vt[k].ireq, vt[k].dreq, vt[k].gnt, vt[k].rv);
         chk($sformatf("v%0d mem_req", k),      32'(mem_req_o),      32'(vt[k].e_req));
         chk($sformatf("v%0d instr_gnt", k),    32'(instr_gnt_o),    32'(vt[k].e_igt));
         chk($sformatf("v%0d data_gnt", k),     32'(data_gnt_o),     32'(vt[k].e_dgt));
         chk($sformatf("v%0d instr_rvalid", k), 32'(instr_rvalid_o), 32'(vt[k].e_irv));
         chk($sformatf("v%0d data_rvalid", k),  32'(data_rvalid_o),  32'(vt[k].e_drv));
         if (vt[k].e_irv || vt[k].e_drv) begin
            chk($sformatf("v%0d instr_rdata", k), instr_rdata_o, 32'h13);
            chk($sformatf("v%0d data_rdata", k),  data_rdata_o,  32'h13);
         end
         if (vt[k].chk_bus) begin
            chk($sformatf("v%0d mem_addr", k),  mem_addr_o,      vt[k].e_addr);
            chk($sformatf("v%0d mem_we", k),    32'(mem_we_o),   32'(vt[k].e_we));
            chk($sformatf("v%0d mem_be", k),    32'(mem_be_o),   32'(vt[k].e_be));
            chk($sformatf("v%0d mem_wdata", k), mem_wdata_o,     vt[k].e_wdata);
         end
      end

      // Contention: memory always ready, both requesters always asking.
      grants = 0;
      last_cyc = 0;
      for (int c = 0; c < 40 && grants < 10; c++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
         if (instr_gnt_o && data_gnt_o)
            chk("cont both_gnt", 32'd1, 32'd0);
         if (instr_gnt_o || data_gnt_o) begin
            exp_i = (grants % 5 == 4);
            chk($sformatf("cont order%0d", grants), 32'(instr_gnt_o), 32'(exp_i));
            if (exp_i)
               chk($sformatf("cont starve_clr%0d", grants), 32'(dut.starve_cnt), 32'd0);
            if (grants > 0)
               chk($sformatf("cont spacing%0d", grants), 32'(c - last_cyc), 32'd3);
            last_cyc = c;
            grants++;
         end
      end
      chk("cont grants", 32'(grants), 32'd10);

      // Reset while a data transaction sits in RESP.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("rst data_gnt", 32'(data_gnt_o), 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst starve_pre", 32'(dut.starve_cnt), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst data_rvalid",  32'(data_rvalid_o),    32'd0);
      chk("rst instr_rvalid", 32'(instr_rvalid_o),   32'd0);
      chk("rst mem_req",      32'(mem_req_o),        32'd0);
      chk("rst state",        32'(int'(dut.state)),  32'd0);
      chk("rst starve_cnt",   32'(dut.starve_cnt),   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
